// File: rtl/fyp_gen_pkg.sv
// Shared types and constants for the fyp packet generator.
// FYP_GEN_SEQ_EN (optional) puts a frame sequence number in payload bytes 0..3.
package fyp_gen_pkg;

   localparam int DATA_W      = 32;
   localparam int EMPTY_W     = 2;
   localparam int IDX_W       = 9;
   localparam int GAP_W       = 8;
   localparam int HDR_BYTES   = 14;
   localparam int PAYLOAD_MIN = 46;
   localparam int PAYLOAD_MAX = 1500;
   localparam int IFG_MAX     = 255;

   localparam logic [47:0] DEF_DST_MAC   = 48'h001C_2317_4ACB;
   localparam logic [47:0] DEF_SRC_MAC   = 48'h000A_3500_0001;
   localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } gen_state_t;

   function automatic int frame_words(input int payload);
      return (HDR_BYTES + payload + 3) / 4;
   endfunction

   function automatic int eop_empty(input int payload);
      return (4 - ((HDR_BYTES + payload) % 4)) % 4;
   endfunction

endpackage

// File: rtl/fyp_gen_word_builder.sv
// Combinational frame-word builder: word index -> data/sop/eop/empty.
// With FYP_GEN_SEQ_EN a sequence number replaces payload bytes 0..3.
module fyp_gen_word_builder
   import fyp_gen_pkg::*;
#(
   parameter logic [47:0] DST_MAC       = DEF_DST_MAC,
   parameter logic [47:0] SRC_MAC       = DEF_SRC_MAC,
   parameter logic [15:0] ETHERTYPE     = DEF_ETHERTYPE,
   parameter int          PAYLOAD_BYTES = PAYLOAD_MIN
) (
   input  logic [IDX_W-1:0]   word_idx,
`ifdef FYP_GEN_SEQ_EN
   input  logic [31:0]        seq_num,
`endif
   output logic [DATA_W-1:0]  data,
   output logic               sop,
   output logic               eop,
   output logic [EMPTY_W-1:0] empty
);

   localparam int FRAME_LEN = HDR_BYTES + PAYLOAD_BYTES;
   localparam int N_WORDS   = frame_words(PAYLOAD_BYTES);
   localparam int EOP_EMPTY = eop_empty(PAYLOAD_BYTES);

   function automatic logic [7:0] byte_at(input int b);
      logic [47:0] sh;
      int          k;
      k  = b - HDR_BYTES;
      sh = '0;
      if (b >= FRAME_LEN) return 8'h00;
      if (b < 6) begin
         sh = DST_MAC >> (8 * (5 - b));
         return sh[7:0];
      end
      if (b < 12) begin
         sh = SRC_MAC >> (8 * (11 - b));
         return sh[7:0];
      end
      if (b < HDR_BYTES) begin
         sh = {32'd0, ETHERTYPE} >> (8 * (13 - b));
         return sh[7:0];
      end
`ifdef FYP_GEN_SEQ_EN
      if (k < 4) begin
         sh = {16'd0, seq_num} >> (8 * (3 - k));
         return sh[7:0];
      end
`endif
      return 8'(k);
   endfunction

   // Bytes are shifted in from the low end so byte 0 lands on [31:24].
   always_comb begin
      data = '0;
      for (int ln = 0; ln < 4; ln++)
         data = {data[DATA_W-9:0], byte_at(int'(word_idx) * 4 + ln)};
   end

   always_comb begin
      sop   = (word_idx == '0);
      eop   = (word_idx == IDX_W'(N_WORDS - 1));
      empty = eop ? EMPTY_W'(EOP_EMPTY) : '0;
   end

endmodule

// File: rtl/fyp_packet_generator.sv
// Ethernet test-traffic source: fixed frames on Avalon-ST TX, RX drained.
// Define FYP_GEN_SEQ_EN to carry a frame sequence number in the payload.
module fyp_packet_generator
   import fyp_gen_pkg::*;
#(
   parameter logic [47:0] DST_MAC       = DEF_DST_MAC,
   parameter logic [47:0] SRC_MAC       = DEF_SRC_MAC,
   parameter logic [15:0] ETHERTYPE     = DEF_ETHERTYPE,
   parameter int          PAYLOAD_BYTES = PAYLOAD_MIN,
   parameter int          IFG_CYCLES    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        gen_start,
   output logic [31:0] eth_ast_tx_data,
   output logic        eth_ast_tx_sop,
   output logic        eth_ast_tx_eop,
   output logic [1:0]  eth_ast_tx_empty,
   output logic        eth_ast_tx_err,
   output logic        eth_ast_tx_valid,
   input  logic        eth_ast_tx_rdy,
   input  logic [31:0] eth_ast_rx_data,
   input  logic        eth_ast_rx_sop,
   input  logic        eth_ast_rx_eop,
   input  logic        eth_ast_rx_err,
   input  logic [1:0]  eth_ast_rx_empty,
   input  logic        eth_ast_rx_valid,
   output logic        eth_ast_rx_rdy
);

   localparam int             N_WORDS  = frame_words(PAYLOAD_BYTES);
   localparam bit             SKIP_GAP = (IFG_CYCLES == 0);
   localparam logic [GAP_W-1:0] GAP_LAST =
      GAP_W'(SKIP_GAP ? 0 : IFG_CYCLES - 1);

   gen_state_t         state;
   gen_state_t         state_nxt;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   nxt_idx;
   logic [GAP_W-1:0]   gap_cnt;
   logic               load;
   logic               clear;
   logic               last;
   logic               send_done;
   logic               gap_done;
   logic [DATA_W-1:0]  w_data;
   logic               w_sop;
   logic               w_eop;
   logic [EMPTY_W-1:0] w_empty;
   logic               unused_rx;

`ifdef FYP_GEN_SEQ_EN
   logic [31:0] seq_num;
`endif

   assign last      = (idx == IDX_W'(N_WORDS - 1));
   assign send_done = eth_ast_tx_rdy && last;
   assign gap_done  = (gap_cnt == GAP_LAST);

   assign eth_ast_tx_err = 1'b0;
   assign unused_rx = ^{eth_ast_rx_data, eth_ast_rx_sop, eth_ast_rx_eop,
                        eth_ast_rx_err, eth_ast_rx_empty, eth_ast_rx_valid};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (gen_start) state_nxt = ST_SEND;
         ST_SEND: if (send_done) state_nxt = SKIP_GAP ? ST_IDLE : ST_GAP;
         ST_GAP:  if (gap_done)  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // load: present word nxt_idx next cycle; clear: eop word has been taken.
   always_comb begin
      load    = 1'b0;
      clear   = 1'b0;
      nxt_idx = idx;
      unique case (state)
         ST_IDLE: begin
            if (gen_start) begin
               load    = 1'b1;
               nxt_idx = '0;
            end
         end
         ST_SEND: begin
            if (send_done) begin
               clear = 1'b1;
            end else if (eth_ast_tx_rdy) begin
               load    = 1'b1;
               nxt_idx = idx + IDX_W'(1);
            end
         end
         default: ;
      endcase
   end

   fyp_gen_word_builder #(
      .DST_MAC       (DST_MAC),
      .SRC_MAC       (SRC_MAC),
      .ETHERTYPE     (ETHERTYPE),
      .PAYLOAD_BYTES (PAYLOAD_BYTES)
   ) u_builder (
      .word_idx (nxt_idx),
`ifdef FYP_GEN_SEQ_EN
      .seq_num  (seq_num),
`endif
      .data     (w_data),
      .sop      (w_sop),
      .eop      (w_eop),
      .empty    (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx              <= '0;
         gap_cnt          <= '0;
         eth_ast_tx_valid <= 1'b0;
         eth_ast_tx_data  <= '0;
         eth_ast_tx_sop   <= 1'b0;
         eth_ast_tx_eop   <= 1'b0;
         eth_ast_tx_empty <= '0;
         eth_ast_rx_rdy   <= 1'b0;
      end else begin
         eth_ast_rx_rdy <= 1'b1;
         gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
         if (load) begin
            idx              <= nxt_idx;
            eth_ast_tx_valid <= 1'b1;
            eth_ast_tx_data  <= w_data;
            eth_ast_tx_sop   <= w_sop;
            eth_ast_tx_eop   <= w_eop;
            eth_ast_tx_empty <= w_empty;
         end else if (clear) begin
            eth_ast_tx_valid <= 1'b0;
            eth_ast_tx_data  <= '0;
            eth_ast_tx_sop   <= 1'b0;
            eth_ast_tx_eop   <= 1'b0;
            eth_ast_tx_empty <= '0;
         end
      end
   end

`ifdef FYP_GEN_SEQ_EN
   always_ff @(posedge clk) begin
      if (!rst_n)     seq_num <= '0;
      else if (clear) seq_num <= seq_num + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fyp_packet_generator.sv
// Bench for fyp_packet_generator: frame scoreboard plus directed checks.
// Honours FYP_GEN_SEQ_EN when the bench is built with it defined.
module tb_fyp_packet_generator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, gen_start, rdy0, rdy1;
   logic [31:0] d0, d1;
   logic s0, s1, e0, e1, er0, er1, v0, v1, rr0, rr1;
   logic [1:0] m0, m1;
   logic [31:0] rx_data = 32'hDEAD_BEEF;
   logic rx_sop = 1'b1, rx_eop = 1'b0, rx_err = 1'b1, rx_valid = 1'b1;
   logic [1:0] rx_empty = 2'd2;

   fyp_packet_generator dut0 (
      .clk(clk), .rst_n(rst_n), .gen_start(gen_start),
      .eth_ast_tx_data(d0), .eth_ast_tx_sop(s0), .eth_ast_tx_eop(e0),
      .eth_ast_tx_empty(m0), .eth_ast_tx_err(er0), .eth_ast_tx_valid(v0),
      .eth_ast_tx_rdy(rdy0),
      .eth_ast_rx_data(rx_data), .eth_ast_rx_sop(rx_sop),
      .eth_ast_rx_eop(rx_eop), .eth_ast_rx_err(rx_err),
      .eth_ast_rx_empty(rx_empty), .eth_ast_rx_valid(rx_valid),
      .eth_ast_rx_rdy(rr0)
   );

   fyp_packet_generator #(.PAYLOAD_BYTES(47), .IFG_CYCLES(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .gen_start(gen_start),
      .eth_ast_tx_data(d1), .eth_ast_tx_sop(s1), .eth_ast_tx_eop(e1),
      .eth_ast_tx_empty(m1), .eth_ast_tx_err(er1), .eth_ast_tx_valid(v1),
      .eth_ast_tx_rdy(rdy1),
      .eth_ast_rx_data(rx_data), .eth_ast_rx_sop(rx_sop),
      .eth_ast_rx_eop(rx_eop), .eth_ast_rx_err(rx_err),
      .eth_ast_rx_empty(rx_empty), .eth_ast_rx_valid(rx_valid),
      .eth_ast_rx_rdy(rr1)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit armed = 1'b0;
   bit rst_smp = 1'b0;

   int pos [2];
   int unsigned fcnt [2];
   int wc0 = 0, wc1 = 0;
   logic [31:0] acc0 [$];
   int sop0q [$], sop1q [$];
   int fl0 [$], fl1 [$];
   logic [31:0] last0 [$], last1 [$];
   logic [1:0] lemp0 [$], lemp1 [$];

   always @(posedge clk) begin
      cyc++;
      rst_smp = rst_n;
      armed = 1'b1;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Frame byte b of frame number fnum for a given payload length.
   function automatic logic [7:0] frame_byte(input int pl, input int b,
                                             input int unsigned fnum);
      logic [111:0] hdr;
      logic [111:0] t;
      int k;
      hdr = {48'h001C23174ACB, 48'h000A35000001, 16'h88B5};
      k = b - 14;
      if (b >= 14 + pl) return 8'h00;
      if (b < 14) begin
         t = hdr << (8 * b);
         return t[111:104];
      end
`ifdef FYP_GEN_SEQ_EN
      if (k < 4) return 8'(fnum >> (8 * (3 - k)));
`else
      if (fnum == 32'hFFFF_FFFF) return 8'h00;
`endif
      return 8'(k % 256);
   endfunction

   function automatic logic [31:0] exp_word(input int pl, input int p,
                                            input int unsigned fnum);
      return {frame_byte(pl, 4*p, fnum), frame_byte(pl, 4*p + 1, fnum),
              frame_byte(pl, 4*p + 2, fnum), frame_byte(pl, 4*p + 3, fnum)};
   endfunction

   task automatic model_cmp(input int d, input int pl, input logic v,
                            input logic rdy, input logic sop,
                            input logic eop, input logic [31:0] data,
                            input logic [1:0] emp, input logic err,
                            input logic rxr);
      int nw, ew;
      nw = (14 + pl + 3) / 4;
      ew = 4 * nw - (14 + pl);
      chk($sformatf("d%0d_tx_err", d), err, 0);
      chk($sformatf("d%0d_rx_rdy", d), rxr, 1);
      if (v) begin
         chk($sformatf("d%0d_data_w%0d", d, pos[d]), data,
             exp_word(pl, pos[d], fcnt[d]));
         chk($sformatf("d%0d_sop_w%0d", d, pos[d]), sop, pos[d] == 0);
         chk($sformatf("d%0d_eop_w%0d", d, pos[d]), eop, pos[d] == nw - 1);
         chk($sformatf("d%0d_empty_w%0d", d, pos[d]), emp,
             (pos[d] == nw - 1) ? ew : 0);
         if (rdy) begin
            if (pos[d] == nw - 1) begin
               pos[d] = 0;
               fcnt[d]++;
            end else begin
               pos[d]++;
            end
         end
      end else begin
         chk($sformatf("d%0d_idle_sop", d), sop, 0);
         chk($sformatf("d%0d_idle_eop", d), eop, 0);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         if (!rst_smp) begin
            chk("rst_v0", v0, 0);
            chk("rst_d0", d0, 0);
            chk("rst_sop_eop0", {s0, e0}, 0);
            chk("rst_empty0", m0, 0);
            chk("rst_rxrdy0", rr0, 0);
            chk("rst_v1", v1, 0);
            chk("rst_rxrdy1", rr1, 0);
            pos[0] = 0; pos[1] = 0;
            fcnt[0] = 0; fcnt[1] = 0;
            wc0 = 0; wc1 = 0;
         end else begin
            model_cmp(0, 46, v0, rdy0, s0, e0, d0, m0, er0, rr0);
            model_cmp(1, 47, v1, rdy1, s1, e1, d1, m1, er1, rr1);
            if (v0 && rdy0) begin
               acc0.push_back(d0);
               wc0++;
               if (s0) sop0q.push_back(cyc);
               if (e0) begin
                  fl0.push_back(wc0);
                  last0.push_back(d0);
                  lemp0.push_back(m0);
                  wc0 = 0;
               end
            end
            if (v1 && rdy1) begin
               wc1++;
               if (s1) sop1q.push_back(cyc);
               if (e1) begin
                  fl1.push_back(wc1);
                  last1.push_back(d1);
                  lemp1.push_back(m1);
                  wc1 = 0;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_sop(input string nm);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 80 && !got; i++) begin
         step();
         @(negedge clk);
         if (v0 && s0) got = 1'b1;
      end
      chk(nm, got, 1);
   endtask

`ifdef FYP_GEN_SEQ_EN
   localparam logic [31:0] F0_W3 = 32'h88B5_0000;
`else
   localparam logic [31:0] F0_W3 = 32'h88B5_0001;
`endif

   int k0, bp_frame, drop_frame, vc;

   initial begin
      rst_n = 1'b0; gen_start = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("reset_valid", v0, 0);
      chk("reset_data", d0, 0);
      chk("reset_rx_rdy", rr0, 0);
      step(); rst_n = 1'b1;
      step(); @(negedge clk);
      chk("rx_rdy_after_release", rr0, 1);

      step(); gen_start = 1'b1; k0 = cyc;
      @(negedge clk);
      chk("no_valid_before_latency", v0, 0);
      step(); @(negedge clk);
      chk("w0_valid", v0, 1);
      chk("w0_sop", s0, 1);
      chk("w0_data", d0, 32'h001C_2317);
      step(); @(negedge clk);
      chk("w1_data", d0, 32'h4ACB_000A);
      step(); @(negedge clk);
      chk("w2_data", d0, 32'h3500_0001);
      step(); @(negedge clk);
      chk("w3_data", d0, F0_W3);

      for (int i = 0; i < 120 && !(sop0q.size() >= 2 && sop1q.size() >= 2);
           i++) begin
         step(); @(negedge clk);
      end
      chk("two_sops_d0", sop0q.size() >= 2, 1);
      chk("two_sops_d1", sop1q.size() >= 2, 1);
      chk("sop_latency", sop0q[0], k0 + 1);
      chk("sop_spacing_d0", sop0q[1] - sop0q[0], 18);
      chk("sop_spacing_d1_ifg0", sop1q[1] - sop1q[0], 17);
      chk("f0_len_d0", fl0[0], 15);
      chk("f0_last_d0", last0[0], 32'h2A2B_2C2D);
      chk("f0_empty_d0", lemp0[0], 0);
      chk("f0_len_d1", fl1[0], 16);
      chk("f0_last_d1", last1[0], 32'h2E00_0000);
      chk("f0_empty_d1", lemp1[0], 3);
`ifdef FYP_GEN_SEQ_EN
      chk("seq_f1_w3", acc0[18], 32'h88B5_0000);
      chk("seq_f1_w4", acc0[19], 32'h0001_0405);
`endif

      wait_sop("sop_before_bp");
      bp_frame = fl0.size();
      repeat (5) step();
      rdy0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("bp_hold_valid_%0d", i), v0, 1);
         chk($sformatf("bp_hold_data_%0d", i), d0, 32'h0607_0809);
         step();
      end
      rdy0 = 1'b1;

      wait_sop("sop_before_drop");
      repeat (7) step();
      gen_start = 1'b0;
      drop_frame = fl0.size();
      repeat (15) step();
      vc = 0;
      for (int i = 0; i < 20; i++) begin
         step(); @(negedge clk);
         if (v0) vc++;
      end
      chk("idle_after_drop", vc, 0);
      chk("drop_frame_done", fl0.size(), drop_frame + 1);
      chk("drop_frame_len", fl0[drop_frame], 15);
      chk("bp_frame_len", fl0[bp_frame], 15);

      step(); gen_start = 1'b1;
      wait_sop("sop_before_reset");
      repeat (4) step();
      rst_n = 1'b0;
      @(negedge clk);
      chk("pre_reset_valid", v0, 1);
      step(); @(negedge clk);
      chk("midframe_rst_valid", v0, 0);
      chk("midframe_rst_data", d0, 0);
      chk("midframe_rst_flags", {s0, e0, m0}, 0);
      chk("midframe_rst_rx_rdy", rr0, 0);
      step(); rst_n = 1'b1;
      @(negedge clk);
      step(); @(negedge clk);
      chk("restart_valid", v0, 1);
      chk("restart_sop", s0, 1);
      chk("restart_data", d0, 32'h001C_2317);
      chk("restart_rx_rdy", rr0, 1);

      step(); gen_start = 1'b0;
      repeat (40) step();
      @(negedge clk);
      chk("final_idle", v0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
